// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: oversampling I2C line monitor.
// Synchronises and glitch-filters SCL/SDA on the system clock. Reports
// START / repeated START / STOP, per-bit strobes, assembled bytes, the
// ACK/NACK bit and an optional SCL-low timeout. All outputs are registered.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CLK_DIV       = 1,
  parameter int unsigned FILTER_LEN    = 2,
  parameter int unsigned TIMEOUT_TICKS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       bus_busy,
  output logic       start_pulse,
  output logic       rstart_pulse,
  output logic       stop_pulse,
  output logic       bit_valid,
  output logic       bit_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ack_valid,
  output logic       ack,
  output logic       timeout
);

  // Synchroniser chains
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_s, sda_s;

  // Sample-tick divider
  logic [7:0] div_q, div_d;
  logic       tick;

  // Glitch filter state
  logic       scl_f_q, scl_f_d;
  logic       sda_f_q, sda_f_d;
  logic [3:0] scl_run_q, scl_run_d;
  logic [3:0] sda_run_q, sda_run_d;

  // Previous filtered values (updated every tick)
  logic scl_p_q, scl_p_d;
  logic sda_p_q, sda_p_d;

  // Protocol state
  logic        busy_q, busy_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [19:0] to_cnt_q, to_cnt_d;

  // Registered outputs
  logic       start_q, start_d;
  logic       rstart_q, rstart_d;
  logic       stop_q, stop_d;
  logic       bit_valid_q, bit_valid_d;
  logic       bit_data_q, bit_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       ack_valid_q, ack_valid_d;
  logic       ack_q, ack_d;
  logic       timeout_q, timeout_d;

  // Line events, meaningful only on a tick
  logic scl_hi, start_ev, stop_ev, scl_rise;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign tick     = (div_q == 8'(CLK_DIV - 1));
  assign scl_hi   = scl_p_q & scl_f_q;
  assign start_ev = scl_hi & sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_hi & ~sda_p_q & sda_f_q;
  assign scl_rise = scl_f_q & ~scl_p_q;

  // Shift raw pad values through the synchroniser every clock
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  // Free-running divider producing the sample tick
  always_comb begin
    div_d = tick ? '0 : div_q + 8'd1;
  end

  // Filtered lines only follow the synced value after FILTER_LEN differing ticks
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_run_d = scl_run_q;
    sda_f_d   = sda_f_q;
    sda_run_d = sda_run_q;
    if (tick) begin
      if (scl_s != scl_f_q) begin
        if (scl_run_q + 4'd1 == 4'(FILTER_LEN)) begin
          scl_f_d   = scl_s;
          scl_run_d = '0;
        end else begin
          scl_run_d = scl_run_q + 4'd1;
        end
      end else begin
        scl_run_d = '0;
      end
      if (sda_s != sda_f_q) begin
        if (sda_run_q + 4'd1 == 4'(FILTER_LEN)) begin
          sda_f_d   = sda_s;
          sda_run_d = '0;
        end else begin
          sda_run_d = sda_run_q + 4'd1;
        end
      end else begin
        sda_run_d = '0;
      end
    end
  end

  // Bus conditions, bit/byte assembly, ACK capture and SCL-low timeout
  always_comb begin
    scl_p_d      = scl_p_q;
    sda_p_d      = sda_p_q;
    busy_d       = busy_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    start_d      = 1'b0;
    rstart_d     = 1'b0;
    stop_d       = 1'b0;
    bit_valid_d  = 1'b0;
    bit_data_d   = bit_data_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    ack_valid_d  = 1'b0;
    ack_d        = ack_q;
    timeout_d    = 1'b0;
    if (tick) begin
      scl_p_d = scl_f_q;
      sda_p_d = sda_f_q;
      if (start_ev) begin
        // START (SCL high, so the timeout counter is cleared here too)
        start_d   = ~busy_q;
        rstart_d  = busy_q;
        busy_d    = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else if (stop_ev) begin
        stop_d    = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        if (scl_rise && busy_q) begin
          bit_valid_d = 1'b1;
          bit_data_d  = sda_f_q;
          if (bit_cnt_q == 4'd8) begin
            ack_valid_d = 1'b1;
            ack_d       = ~sda_f_q;
            bit_cnt_d   = '0;
          end else begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              byte_valid_d = 1'b1;
              byte_data_d  = {shift_q[6:0], sda_f_q};
            end
          end
        end
        if (TIMEOUT_TICKS != 0) begin
          if (busy_q && !scl_f_q) begin
            if (to_cnt_q + 20'd1 == 20'(TIMEOUT_TICKS)) begin
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              bit_cnt_d = '0;
              to_cnt_d  = '0;
            end else begin
              to_cnt_d = to_cnt_q + 20'd1;
            end
          end else begin
            to_cnt_d = '0;
          end
        end
      end
    end
  end

  // State registers; reset presents an idle (high) bus everywhere
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      div_q        <= '0;
      scl_f_q      <= 1'b1;
      sda_f_q      <= 1'b1;
      scl_run_q    <= '0;
      sda_run_q    <= '0;
      scl_p_q      <= 1'b1;
      sda_p_q      <= 1'b1;
      busy_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      start_q      <= 1'b0;
      rstart_q     <= 1'b0;
      stop_q       <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_data_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      ack_valid_q  <= 1'b0;
      ack_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      div_q        <= div_d;
      scl_f_q      <= scl_f_d;
      sda_f_q      <= sda_f_d;
      scl_run_q    <= scl_run_d;
      sda_run_q    <= sda_run_d;
      scl_p_q      <= scl_p_d;
      sda_p_q      <= sda_p_d;
      busy_q       <= busy_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      start_q      <= start_d;
      rstart_q     <= rstart_d;
      stop_q       <= stop_d;
      bit_valid_q  <= bit_valid_d;
      bit_data_q   <= bit_data_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      ack_valid_q  <= ack_valid_d;
      ack_q        <= ack_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus_busy     = busy_q;
  assign start_pulse  = start_q;
  assign rstart_pulse = rstart_q;
  assign stop_pulse   = stop_q;
  assign bit_valid    = bit_valid_q;
  assign bit_data     = bit_data_q;
  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign ack_valid    = ack_valid_q;
  assign ack          = ack_q;
  assign timeout      = timeout_q;

endmodule
